led_shift_sequencer: RTL and testbench

//  Command-driven controller for the board's 8-LED rotating shifter. A host (button decoder/UART) issues

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_shift_sequencer_if.sv | 10 +
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_shift_sequencer.sv | 107 ++++++++++
 tb/tb_led_shift_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED shift sequencer.
package led_seq_pkg;

  localparam logic [1:0] OP_LOAD       = 2'd0;
  localparam logic [1:0] OP_SET_PERIOD = 2'd1;
  localparam logic [1:0] OP_START      = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

  localparam int unsigned TICKS_PER_SEC  = 16;
  localparam logic [7:0]  DEFAULT_PERIOD = 8'd15;

  typedef enum logic {StStop, StRun} state_e;

  // dir: 0 rotates left, 1 rotates right
  function automatic logic [7:0] rotate(input logic [7:0] pat, input logic right);
    return right ? {pat[0], pat[7:1]} : {pat[6:0], pat[7]};
  endfunction

endpackage

// File: rtl/led_shift_sequencer_if.sv
// Host command port of the LED shift sequencer: valid/ready with op and data.
interface led_shift_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/led_tick_gen.sv
// Step timebase: prescaler of TICK_DIV cycles feeding a tick counter compared against period.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] period,
  output logic       step
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PresW-1:0] presc_q;
  logic [7:0]       cnt_q;
  logic             tick;

  assign tick = (presc_q == PresW'(TICK_DIV - 1));
  // >= so a period lowered below the running count fires on the next tick
  assign step = en && tick && (cnt_q >= period);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PresW'(1);
      if (tick) begin
        cnt_q <= (cnt_q >= period) ? 8'd0 : cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/led_shift_sequencer.sv
// Command-driven 8-LED rotating shifter: FSM, command decode, pattern and step counting.
// Optional build macro LED_BOUNCE_EN adds direction reversal at the pattern ends.
module led_shift_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 25_000_000,
  parameter logic [7:0]  RESET_PATTERN = 8'b00011111
) (
  input  logic                        clk,
  input  logic                        rst_n,
  led_shift_sequencer_if.slave        cmd,
  output logic [7:0]                  leds,
  output logic                        running,
  output logic                        dir,
  output logic                        step_pulse,
  output logic                        cycle_done
);

  localparam int unsigned TickDiv = CLK_FREQ / TICKS_PER_SEC;

  state_e     state_q;
  logic [7:0] leds_q, period_q, next_leds;
  logic [2:0] steps_q;
  logic       ready_q, dir_q, pulse_q, done_q;
  logic       accept, ctrl_cmd, step_raw, step_fire;
`ifdef LED_BOUNCE_EN
  logic       bounce_q;
`endif

  assign accept    = cmd.cmd_valid && ready_q;
  // LOAD/START/STOP restart timing and take priority over a coincident step
  assign ctrl_cmd  = accept && (cmd.cmd_op != OP_SET_PERIOD);
  assign step_fire = step_raw && !ctrl_cmd;
  assign next_leds = rotate(leds_q, dir_q);

  led_tick_gen #(
    .TICK_DIV (TickDiv)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == StRun),
    .clr    (ctrl_cmd),
    .period (period_q),
    .step   (step_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StStop;
      leds_q   <= RESET_PATTERN;
      period_q <= DEFAULT_PERIOD;
      steps_q  <= '0;
      ready_q  <= 1'b0;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef LED_BOUNCE_EN
      bounce_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      if (step_fire) begin
        leds_q  <= next_leds;
        pulse_q <= 1'b1;
        steps_q <= steps_q + 3'd1;
        done_q  <= (steps_q == 3'd7);
`ifdef LED_BOUNCE_EN
        if (bounce_q && !dir_q && next_leds[7]) dir_q <= 1'b1;
        if (bounce_q && dir_q && next_leds[0])  dir_q <= 1'b0;
`endif
      end
      if (accept) begin
        unique case (cmd.cmd_op)
          OP_LOAD: begin
            leds_q  <= cmd.cmd_data;
            steps_q <= '0;
          end
          OP_SET_PERIOD: period_q <= cmd.cmd_data;
          OP_START: begin
            state_q <= StRun;
            dir_q   <= cmd.cmd_data[0];
            steps_q <= '0;
`ifdef LED_BOUNCE_EN
            bounce_q <= cmd.cmd_data[1];
`endif
          end
          OP_STOP: begin
            state_q <= StStop;
`ifdef LED_BOUNCE_EN
            bounce_q <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign leds          = leds_q;
  assign running       = (state_q == StRun);
  assign dir           = dir_q;
  assign step_pulse    = pulse_q;
  assign cycle_done    = done_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Self-checking bench: directed scenarios plus random commands against a cycle-time reference model.
module tb_led_shift_sequencer;
  import led_seq_pkg::*;

  localparam int unsigned ClkFreq = 160;
  localparam int unsigned TickDiv = ClkFreq / 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] leds;
  logic       running, dir, step_pulse, cycle_done;

  led_shift_sequencer_if cmd_if();

  led_shift_sequencer #(
    .CLK_FREQ      (ClkFreq),
    .RESET_PATTERN (8'h1F)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .leds       (leds),
    .running    (running),
    .dir        (dir),
    .step_pulse (step_pulse),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: timing expressed as absolute cycles/ticks since the last restart
  logic [7:0] m_leds;
  logic       m_run, m_dir, m_pulse, m_done, m_ready, m_bounce;
  int         m_period, m_cyc, m_last, m_nsteps;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] x, input logic right);
    int v;
    v = int'(x);
    if (right) return 8'((v >> 1) + ((v % 2) * 128));
    else       return 8'(((v * 2) % 256) + (v / 128));
  endfunction

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [7:0] d);
    logic acc, stp, ctrl;
    int   t;
    if (!rst_n) begin
      m_leds = 8'h1F; m_run = 0; m_dir = 0; m_pulse = 0; m_done = 0; m_ready = 0;
      m_bounce = 0; m_period = 15; m_cyc = 0; m_last = 0; m_nsteps = 0;
      return;
    end
    acc = v && m_ready;
    m_ready = 1; m_pulse = 0; m_done = 0; stp = 0;
    if (m_run) begin
      m_cyc++;
      if (m_cyc % TickDiv == 0) begin
        t = m_cyc / TickDiv;
        if (t - m_last >= m_period + 1) begin
          stp = 1;
          m_last = t;
        end
      end
    end
    ctrl = acc && (op != OP_SET_PERIOD);
    if (ctrl) begin
      stp = 0; m_cyc = 0; m_last = 0;
    end
    if (stp) begin
      m_leds = rot_ref(m_leds, m_dir);
      m_pulse = 1;
      m_nsteps++;
      m_done = (m_nsteps % 8 == 0);
`ifdef LED_BOUNCE_EN
      if (m_bounce && !m_dir && m_leds[7]) m_dir = 1;
      else if (m_bounce && m_dir && m_leds[0]) m_dir = 0;
`endif
    end
    if (acc) begin
      case (op)
        OP_LOAD:       begin m_leds = d; m_nsteps = 0; end
        OP_SET_PERIOD: m_period = int'(d);
        OP_START: begin
          m_run = 1; m_dir = d[0]; m_nsteps = 0;
`ifdef LED_BOUNCE_EN
          m_bounce = d[1];
`endif
        end
        default:       begin m_run = 0; m_bounce = 0; end
      endcase
    end
  endtask

  task automatic check_all();
    check_eq("leds", leds, m_leds);
    check_eq("running", {7'd0, running}, {7'd0, m_run});
    check_eq("dir", {7'd0, dir}, {7'd0, m_dir});
    check_eq("step_pulse", {7'd0, step_pulse}, {7'd0, m_pulse});
    check_eq("cycle_done", {7'd0, cycle_done}, {7'd0, m_done});
    check_eq("cmd_ready", {7'd0, cmd_if.cmd_ready}, {7'd0, m_ready});
  endtask

  task automatic step_cycle(input logic v, input logic [1:0] op, input logic [7:0] d);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    @(posedge clk);
    model_edge(v, op, d);
    #1;
    check_all();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, OP_LOAD, 8'h00);
  endtask

  initial begin
    logic [7:0] bseq [15];
    logic [1:0] rop;
    logic [7:0] rdat;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 8'h00;

    // Reset and ready release
    rst_n = 1'b0;
    idle(3);
    check_eq("rst_leds", leds, 8'h1F);
    check_eq("rst_running", {7'd0, running}, 8'h00);
    check_eq("rst_ready", {7'd0, cmd_if.cmd_ready}, 8'h00);
    rst_n = 1'b1;
    idle(1);
    check_eq("ready_after_release", {7'd0, cmd_if.cmd_ready}, 8'h01);

    // Default period: one step per 160 cycles, left
    step_cycle(1'b1, OP_START, 8'h00);
    idle(159);
    check_eq("no_step_before_160", {7'd0, step_pulse}, 8'h00);
    idle(1);
    check_eq("step1_leds", leds, 8'h3E);
    check_eq("step1_pulse", {7'd0, step_pulse}, 8'h01);
    idle(1);
    check_eq("pulse_one_cycle", {7'd0, step_pulse}, 8'h00);
    idle(159);
    check_eq("step2_leds", leds, 8'h7C);

    // Fastest period, rotate right, 8-step wrap
    step_cycle(1'b1, OP_LOAD, 8'h1F);
    step_cycle(1'b1, OP_SET_PERIOD, 8'h00);
    step_cycle(1'b1, OP_START, 8'h01);
    idle(10);
    check_eq("right_step1", leds, 8'h8F);
    idle(10);
    check_eq("right_step2", leds, 8'hC7);
    idle(50);
    check_eq("right_step7_nodone", {7'd0, cycle_done}, 8'h00);
    idle(10);
    check_eq("right_step8_leds", leds, 8'h1F);
    check_eq("right_step8_done", {7'd0, cycle_done}, 8'h01);

    // LOAD colliding with a step edge wins and restarts timing
    idle(9);
    step_cycle(1'b1, OP_LOAD, 8'h81);
    check_eq("load_on_step_leds", leds, 8'h81);
    check_eq("load_on_step_pulse", {7'd0, step_pulse}, 8'h00);
    idle(9);
    check_eq("load_hold", leds, 8'h81);
    idle(1);
    check_eq("after_load_step", leds, 8'hC0);

    // STOP mid-interval freezes; START gives a full interval
    idle(4);
    step_cycle(1'b1, OP_STOP, 8'h00);
    check_eq("stop_running", {7'd0, running}, 8'h00);
    idle(500);
    check_eq("stop_frozen", leds, 8'hC0);
    step_cycle(1'b1, OP_START, 8'h00);
    idle(9);
    check_eq("restart_wait", leds, 8'hC0);
    idle(1);
    check_eq("restart_step", leds, 8'h81);

`ifdef LED_BOUNCE_EN
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    step_cycle(1'b1, OP_LOAD, 8'h01);
    step_cycle(1'b1, OP_START, 8'h02);
    for (int i = 0; i < 15; i++) begin
      idle(10);
      check_eq("bounce_seq", leds, bseq[i]);
    end
`else
    bseq = '{default: 8'h00};
`endif

    // Random commands with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) begin
        rop  = 2'($urandom_range(0, 3));
        rdat = 8'($urandom);
        if (rop == OP_SET_PERIOD && $urandom_range(0, 9) != 0) rdat = 8'($urandom_range(0, 3));
        step_cycle(1'b1, rop, rdat);
      end else begin
        idle(1);
      end
    end
    rst_n = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
